skid_flopr: RTL and testbench
=============================

Name: skid_flopr

Overview:
- Parametrised successor to the resettable pipeline flop: a WIDTH-bit pipeline register with valid/ready handshake, a one-entry skid buffer and synchronous flush.
- Sits between RISC-V pipeline stages (e.g. IF/ID, ID/EX).
- Full throughput under backpressure: in_ready is purely registered, so no combinational ready path crosses the stage.

Parameters:
- WIDTH, 32: payload width in bits.
- RESET_VAL, '0: value of out_data after reset and flush.
- CNT_WIDTH, 16: stall counter width (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all held entries.
- in_valid  input  1  upstream has data.
- in_ready  output  1  stage can accept data.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  stage holds data.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  downstream payload.
- perf_stall_cnt  output  CNT_WIDTH  present only with SKID_FLOPR_PERF_EN.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values: out_valid=0, in_ready=1, out_data=RESET_VAL, skid empty, perf_stall_cnt=0.
- Reset takes effect immediately, independent of clk.
- Handshakes:
  - Upstream transfer when in_valid && in_ready at a rising edge.
  - Downstream transfer when out_valid && out_ready at a rising edge.
  - in_ready and out_valid/out_data are driven from flops only.
- State machine (skid_state_t):
  - EMPTY: main and skid invalid.
  - MAIN: main valid, skid invalid.
  - SKID: both valid; in_ready=0.
- Transitions (f = upstream transfer, d = downstream transfer):
  - EMPTY: f -> MAIN, main<=in_data.
  - MAIN: f&&d -> MAIN, main<=in_data. f&&!d -> SKID, skid<=in_data. !f&&d -> EMPTY. Otherwise hold.
  - SKID: d -> MAIN, main<=skid. Otherwise hold. Upstream is blocked because in_ready=0.
- Latency: 1 cycle from accept to out_valid in EMPTY/MAIN.
- Throughput: 1 transfer per cycle when out_ready is held high.
- Ordering: strict FIFO order; no data is dropped or duplicated.
- out_data holds its last value while out_valid=0. It is updated only on load or flush.
- flush:
  - Next edge goes to EMPTY, out_data<=RESET_VAL, in_ready=1.
  - Any same-cycle upstream transfer is discarded.
  - Flush beats handshake; reset beats flush.
- Reset mid-transfer: all entries are lost, with no partial state.
- out_ready must not depend on out_valid combinationally. in_valid is allowed to drop without transfer (no stability requirement).

Optional Feature:
- Macro SKID_FLOPR_PERF_EN.
- With the macro:
  - perf_stall_cnt increments each cycle out_valid && !out_ready.
  - It saturates at all-ones and clears on reset only; flush does not clear it.
- Without the macro: the port and counter do not exist, with zero area.

Decomposition:
- Package skid_pkg holds:
  - typedef enum logic [1:0] skid_state_t {EMPTY, MAIN, SKID}.
  - localparam default WIDTH=32.
- Natural sub-module: flopenr #(WIDTH, RESET_VAL), a resettable enable flop with sync clear.
  - Instanced twice: main and skid registers.
  - Replaces plain flopr usage for stall-capable stages.

Test Plan:
- Reset: assert reset mid-cycle -> out_valid=0, in_ready=1, out_data=0 before the next edge.
- Streaming: out_ready=1, send 0x1,0x2,...,0xA one per cycle -> outputs appear 1 cycle later in order, no bubbles.
- Backpressure:
  - Send 0xAAAA_0001, 0xAAAA_0002 with out_ready=0 -> state SKID, in_ready=0.
  - Release out_ready -> 0x..01 then 0x..02 in order.
- Flush in SKID with in_valid=1, in_data=0xDEAD_BEEF -> next cycle out_valid=0, in_ready=1, out_data=0, 0xDEADBEEF never emitted.
- Random: 1000 cycles of $urandom data with random in_valid/out_ready -> scoreboard matches exactly, in_ready never high in SKID.
- Perf (SKID_FLOPR_PERF_EN, CNT_WIDTH=4): hold out_valid with out_ready=0 for 20 cycles -> perf_stall_cnt=15, saturated.

Source files
------------

// File: rtl/skid_pkg.sv
// rtl/skid_pkg.sv - shared types and defaults for the skid_flopr pipeline stage
//
// Purpose: holds the skid buffer state encoding and the default payload width
// used by skid_flopr and its enable-flop sub-module.
package skid_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // main and skid both invalid
    MAIN  = 2'd1,  // main valid, skid invalid
    SKID  = 2'd2   // both valid, upstream blocked
  } skid_state_t;

endpackage

// File: rtl/flopenr.sv
// rtl/flopenr.sv - resettable enable flop with synchronous clear
//
// Purpose: WIDTH-bit register that loads d when en is high, is forced to
// RESET_VAL by a synchronous clr (clr wins over en) and by an asynchronous
// active-high reset.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset to RESET_VAL
//   clr    in   synchronous clear to RESET_VAL
//   en     in   load enable
//   d      in   WIDTH-bit data to load
//   q      out  WIDTH-bit registered value
module flopenr
  import skid_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = RESET_VAL;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/skid_flopr.sv
// rtl/skid_flopr.sv - valid/ready pipeline register with one-entry skid buffer and flush
//
// Purpose: WIDTH-bit pipeline stage between RISC-V pipeline stages. A main
// register feeds the output; a skid register catches the one beat that arrives
// while the output is stalled, so in_ready can come straight from a flop and
// the stage still runs at one transfer per cycle.
// Optional feature: define SKID_FLOPR_PERF_EN to add the CNT_WIDTH parameter
// and the saturating perf_stall_cnt output.
// Ports:
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-high reset
//   flush           in   synchronous clear of all held entries
//   in_valid        in   upstream has data
//   in_ready        out  stage can accept data (registered)
//   in_data         in   upstream payload
//   out_valid       out  stage holds data (registered)
//   out_ready       in   downstream accepts
//   out_data        out  downstream payload (registered)
//   perf_stall_cnt  out  cycles with out_valid && !out_ready (SKID_FLOPR_PERF_EN only)
module skid_flopr
  import skid_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef SKID_FLOPR_PERF_EN
  ,
  parameter int               CNT_WIDTH = 16
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data
`ifdef SKID_FLOPR_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_stall_cnt
`endif
);

  skid_state_t      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             up_xfer, dn_xfer;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_data;

  assign up_xfer = in_valid && in_ready_q;
  assign dn_xfer = out_valid_q && out_ready;

  // State register. Handshake outputs are flopped alongside the state so that
  // neither in_ready nor out_valid has a combinational path from any input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next state. Flush overrides any handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (up_xfer) state_d = MAIN;
        MAIN: begin
          if (up_xfer && !dn_xfer) begin
            state_d = SKID;
          end else if (!up_xfer && dn_xfer) begin
            state_d = EMPTY;
          end
        end
        SKID:    if (dn_xfer) state_d = MAIN;
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d  = (state_d != SKID);
    out_valid_d = (state_d != EMPTY);
  end

  // Register load controls. Flush is applied through the flops' sync clear,
  // which takes priority over these enables.
  always_comb begin
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    case (state_q)
      EMPTY: main_en = up_xfer;
      MAIN: begin
        main_en = up_xfer && dn_xfer;
        skid_en = up_xfer && !dn_xfer;
      end
      SKID: begin
        // Draining the skid entry promotes it to main; upstream is blocked.
        main_en = dn_xfer;
        main_d  = skid_data;
      end
      default: ;
    endcase
  end

  flopenr #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_main (
    .clk  (clk),
    .reset(reset),
    .clr  (flush),
    .en   (main_en),
    .d    (main_d),
    .q    (out_data)
  );

  flopenr #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_skid (
    .clk  (clk),
    .reset(reset),
    .clr  (flush),
    .en   (skid_en),
    .d    (in_data),
    .q    (skid_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

`ifdef SKID_FLOPR_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating stall counter; only reset clears it, flush leaves it alone.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_skid_flopr.sv
// tb/tb_skid_flopr.sv - self-checking bench for skid_flopr against a queue model
module tb_skid_flopr;

  localparam int          WIDTH     = 32;
  localparam logic [31:0] RESET_VAL = 32'h0;
  localparam int          CNT_WIDTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_data;
`ifdef SKID_FLOPR_PERF_EN
  logic [CNT_WIDTH-1:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model: the stage is a two-deep FIFO whose output register
  // keeps the last value it showed once the FIFO runs dry.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_last;
  int               m_cnt;

  always #5 clk = ~clk;

`ifdef SKID_FLOPR_PERF_EN
  skid_flopr #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .perf_stall_cnt(perf_stall_cnt)
  );
`else
  skid_flopr #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );
`endif

  function automatic logic [WIDTH-1:0] exp_data();
    return (mq.size() > 0) ? mq[0] : m_last;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last = RESET_VAL;
    m_cnt  = 0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic step();
    bit f, d;
    f = in_valid && (mq.size() < 2);
    d = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (!d && mq.size() > 0 && m_cnt < (1 << CNT_WIDTH) - 1) m_cnt++;
    else if (d && !out_ready) m_cnt = m_cnt;
    if (flush) begin
      mq.delete();
      m_last = RESET_VAL;
    end else begin
      if (d) m_last = mq.pop_front();
      if (f) mq.push_back(in_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b0;
    step();
    step();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++;
    if (out_data !== RESET_VAL) begin errors++; $display("FAIL reset_out_data got %h exp %h", out_data, RESET_VAL); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        errors++;
        $display("FAIL stream_beat%0d got v=%0b d=%h exp v=1 d=%h", i, out_valid, out_data, 32'(i));
      end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready got %0b exp 1", in_ready); end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd10) begin
      errors++;
      $display("FAIL stream_drain got v=%0b d=%h exp v=0 d=0000000a", out_valid, out_data);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA_0001;
    step();
    in_data   = 32'hAAAA_0002;
    step();
    in_valid  = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_skid_in_ready got %0b exp 0", in_ready); end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL bp_hold got v=%0b d=%h exp v=1 d=aaaa0001", out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hAAAA_0002 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second got v=%0b d=%h r=%0b exp v=1 d=aaaa0002 r=1", out_valid, out_data, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5555_0001;
    step();
    in_data   = 32'h5555_0002;
    step();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_skid got %0b exp 0", in_ready); end
    in_data = 32'hDEAD_BEEF;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== RESET_VAL) begin
      errors++;
      $display("FAIL flush_state got v=%0b r=%0b d=%h exp v=0 r=1 d=%h", out_valid, in_ready, out_data, RESET_VAL);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || out_data === 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL flush_no_emit got v=%0b d=%h exp v=0 d!=deadbeef", out_valid, out_data);
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      flush     = ($urandom_range(0, 40) == 0);
      step();
      checks++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) || out_data !== exp_data()) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cyc%0d got v=%0b r=%0b d=%h exp v=%0b r=%0b d=%h", i,
                   out_valid, in_ready, out_data, mq.size() > 0, mq.size() < 2, exp_data());
      end
`ifdef SKID_FLOPR_PERF_EN
      checks++;
      if (perf_stall_cnt !== CNT_WIDTH'(m_cnt)) begin
        errors++;
        $display("FAIL random_perf got %0d exp %0d", perf_stall_cnt, m_cnt);
      end
`endif
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

`ifdef SKID_FLOPR_PERF_EN
  task automatic test_perf();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (perf_stall_cnt !== '0) begin errors++; $display("FAIL perf_reset got %0d exp 0", perf_stall_cnt); end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0BAD_F00D;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 5) begin
        checks++;
        if (perf_stall_cnt !== 4'd5) begin errors++; $display("FAIL perf_count5 got %0d exp 5", perf_stall_cnt); end
      end
    end
    checks++;
    if (perf_stall_cnt !== 4'd15) begin errors++; $display("FAIL perf_saturate got %0d exp 15", perf_stall_cnt); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (perf_stall_cnt !== 4'd15) begin errors++; $display("FAIL perf_flush_keep got %0d exp 15", perf_stall_cnt); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_random();
`ifdef SKID_FLOPR_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
